hue_pwm_driver: RTL and testbench

Downstream consumer of the state timebase in the RGB colour-wheel path. Takes the 1 ms tick and the 6-state hue sector index. Ramps three per-channel duty values up or down, one step per tick. Drives three glitch-free PWM outputs whose period is INC_DEC_MAX clocks, with duty changes applied only at period boundaries.

---
 rtl/hue_pwm_driver_if.sv | 38 +++
 rtl/hue_pwm_driver.sv | 118 +++++++++++
 tb/tb_hue_pwm_driver.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/hue_pwm_driver_if.sv
// Bundle between the hue timebase and hue_pwm_driver: tick/sector in, duties and PWM pins out.
// The duty width follows INC_DEC_MAX so the interface and driver must share that parameter.
interface hue_pwm_driver_if #(
  parameter int INC_DEC_MAX = 167
);
  localparam int DW = $clog2(INC_DEC_MAX + 1);

  logic          ms_tick;
  logic [2:0]    current_state;
  logic [DW-1:0] red_duty;
  logic [DW-1:0] green_duty;
  logic [DW-1:0] blue_duty;
  logic          red_pwm;
  logic          green_pwm;
  logic          blue_pwm;

  modport master (
    output ms_tick,
    output current_state,
    input  red_duty,
    input  green_duty,
    input  blue_duty,
    input  red_pwm,
    input  green_pwm,
    input  blue_pwm
  );

  modport slave (
    input  ms_tick,
    input  current_state,
    output red_duty,
    output green_duty,
    output blue_duty,
    output red_pwm,
    output green_pwm,
    output blue_pwm
  );
endinterface

// File: rtl/hue_pwm_driver.sv
// Colour-wheel PWM driver: ramps R/G/B duties once per ms tick and drives glitch-free PWM.
// Optional macro LED_ACTIVE_LOW_EN inverts the PWM pins for common-anode LEDs.
module hue_pwm_driver #(
  parameter int INC_DEC_MAX = 167,
  parameter int STATE_COUNT = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  hue_pwm_driver_if.slave   bus
);

  localparam int DW = $clog2(INC_DEC_MAX + 1);
  localparam logic [DW-1:0] DUTY_MAX = DW'(INC_DEC_MAX);
  localparam logic [DW-1:0] CNT_LAST = DW'(INC_DEC_MAX - 1);
  localparam int RED   = 0;
  localparam int GREEN = 1;
  localparam int BLUE  = 2;

`ifdef LED_ACTIVE_LOW_EN
  localparam logic PWM_ON = 1'b0;
`else
  localparam logic PWM_ON = 1'b1;
`endif

  typedef enum logic [2:0] {
    MODE_HOLD,
    MODE_INC,
    MODE_DEC,
    MODE_HIGH,
    MODE_LOW
  } mode_t;

  mode_t         mode     [3];
  logic [DW-1:0] duty_q   [3];
  logic [DW-1:0] shadow_q [3];
  logic [DW-1:0] pwm_cnt;
  logic [2:0]    pwm_q;

  function automatic logic [DW-1:0] step_duty(input mode_t m, input logic [DW-1:0] duty);
    logic [DW-1:0] nxt;
    nxt = duty;
    case (m)
      MODE_INC:  nxt = (duty >= DUTY_MAX) ? DUTY_MAX : duty + DW'(1);
      MODE_DEC:  nxt = (duty == '0) ? '0 : duty - DW'(1);
      MODE_HIGH: nxt = DUTY_MAX;
      MODE_LOW:  nxt = '0;
      default:   nxt = duty;
    endcase
    return nxt;
  endfunction

  // Exactly one channel ramps per sector; out-of-range sectors freeze everything.
  always_comb begin
    mode[RED]   = MODE_HOLD;
    mode[GREEN] = MODE_HOLD;
    mode[BLUE]  = MODE_HOLD;
    if (int'(bus.current_state) < STATE_COUNT) begin
      case (bus.current_state)
        3'd0: begin mode[RED] = MODE_HIGH; mode[GREEN] = MODE_INC;  mode[BLUE] = MODE_LOW;  end
        3'd1: begin mode[RED] = MODE_DEC;  mode[GREEN] = MODE_HIGH; mode[BLUE] = MODE_LOW;  end
        3'd2: begin mode[RED] = MODE_LOW;  mode[GREEN] = MODE_HIGH; mode[BLUE] = MODE_INC;  end
        3'd3: begin mode[RED] = MODE_LOW;  mode[GREEN] = MODE_DEC;  mode[BLUE] = MODE_HIGH; end
        3'd4: begin mode[RED] = MODE_INC;  mode[GREEN] = MODE_LOW;  mode[BLUE] = MODE_HIGH; end
        3'd5: begin mode[RED] = MODE_HIGH; mode[GREEN] = MODE_LOW;  mode[BLUE] = MODE_DEC;  end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q[RED]   <= DUTY_MAX;
      duty_q[GREEN] <= '0;
      duty_q[BLUE]  <= '0;
    end else if (bus.ms_tick) begin
      for (int ch = 0; ch < 3; ch++) begin
        duty_q[ch] <= step_duty(mode[ch], duty_q[ch]);
      end
    end
  end

  // Shadows latch on the last count of a period, so a whole period always uses one duty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt         <= '0;
      shadow_q[RED]   <= DUTY_MAX;
      shadow_q[GREEN] <= '0;
      shadow_q[BLUE]  <= '0;
    end else begin
      if (pwm_cnt == CNT_LAST) begin
        pwm_cnt <= '0;
        for (int ch = 0; ch < 3; ch++) begin
          shadow_q[ch] <= duty_q[ch];
        end
      end else begin
        pwm_cnt <= pwm_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_q <= {3{~PWM_ON}};
    end else begin
      for (int ch = 0; ch < 3; ch++) begin
        pwm_q[ch] <= (pwm_cnt < shadow_q[ch]) ? PWM_ON : ~PWM_ON;
      end
    end
  end

  assign bus.red_duty   = duty_q[RED];
  assign bus.green_duty = duty_q[GREEN];
  assign bus.blue_duty  = duty_q[BLUE];
  assign bus.red_pwm    = pwm_q[RED];
  assign bus.green_pwm  = pwm_q[GREEN];
  assign bus.blue_pwm   = pwm_q[BLUE];

endmodule

// File: tb/tb_hue_pwm_driver.sv
// Scoreboard bench for hue_pwm_driver with INC_DEC_MAX=8; expectations come from a
// per-edge duty history and a period-level PWM rule. Honours LED_ACTIVE_LOW_EN.
module tb_hue_pwm_driver;

  localparam int M = 8;

`ifdef LED_ACTIVE_LOW_EN
  localparam bit ACT_LOW = 1'b1;
`else
  localparam bit ACT_LOW = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  hue_pwm_driver_if #(.INC_DEC_MAX(M)) bus();

  hue_pwm_driver #(.INC_DEC_MAX(M), .STATE_COUNT(6)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int       edge_n;
    int       r;
    int       g;
    int       b;
    logic [2:0] pwm;
  } exp_t;

  exp_t  exp_q[$];
  int    hist_r[$];
  int    hist_g[$];
  int    hist_b[$];
  int    total = 0;
  int    bad   = 0;
  string mode_tbl[8] = '{"HIL", "DHL", "LHI", "LDH", "ILH", "HLD", "---", "---"};

  function automatic int next_duty(int st, int ch, int d, bit tk);
    string s;
    byte   c;
    if (!tk) return d;
    s = mode_tbl[st];
    c = s[ch];
    case (c)
      "I": return (d + 1 > M) ? M : d + 1;
      "D": return (d - 1 < 0) ? 0 : d - 1;
      "H": return M;
      "L": return 0;
      default: return d;
    endcase
  endfunction

  function automatic logic pin(bit on);
    return ACT_LOW ? !on : on;
  endfunction

  task automatic checkOutput(string name, int act, int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic modelReset();
    hist_r.delete(); hist_g.delete(); hist_b.delete();
    hist_r.push_back(M); hist_g.push_back(0); hist_b.push_back(0);
  endtask

  // Called at a falling edge: drives one cycle of inputs and predicts the next rising edge.
  task automatic applyStimulus(int st, bit tk);
    int   n, c, s, src;
    exp_t e;
    bus.current_state = 3'(st);
    bus.ms_tick       = tk;
    n = hist_r.size();
    hist_r.push_back(next_duty(st, 0, hist_r[n-1], tk));
    hist_g.push_back(next_duty(st, 1, hist_g[n-1], tk));
    hist_b.push_back(next_duty(st, 2, hist_b[n-1], tk));
    c   = (n - 1) % M;
    s   = M * ((n - 1) / M);
    src = (s == 0) ? 0 : s - 1;
    e.edge_n = n;
    e.r      = hist_r[n];
    e.g      = hist_g[n];
    e.b      = hist_b[n];
    e.pwm    = {pin(c < hist_r[src]), pin(c < hist_g[src]), pin(c < hist_b[src])};
    exp_q.push_back(e);
    @(negedge clk);
    bus.ms_tick = 1'b0;
  endtask

  task automatic checkResetValues(string tag);
    checkOutput({tag, "_red_duty"},   int'(bus.red_duty),   M);
    checkOutput({tag, "_green_duty"}, int'(bus.green_duty), 0);
    checkOutput({tag, "_blue_duty"},  int'(bus.blue_duty),  0);
    checkOutput({tag, "_pwm"}, int'({bus.red_pwm, bus.green_pwm, bus.blue_pwm}),
                int'({pin(1'b0), pin(1'b0), pin(1'b0)}));
  endtask

  // Called at a falling edge; asserts reset between edges so the check proves asynchrony.
  task automatic asyncReset(string tag);
    bus.ms_tick = 1'b0;
    #2 rst_n = 1'b0;
    #1 checkResetValues(tag);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checkOutput($sformatf("e%0d_red_duty", e.edge_n),   int'(bus.red_duty),   e.r);
        checkOutput($sformatf("e%0d_green_duty", e.edge_n), int'(bus.green_duty), e.g);
        checkOutput($sformatf("e%0d_blue_duty", e.edge_n),  int'(bus.blue_duty),  e.b);
        checkOutput($sformatf("e%0d_pwm_rgb", e.edge_n),
                    int'({bus.red_pwm, bus.green_pwm, bus.blue_pwm}), int'(e.pwm));
      end
    end
  end

  initial begin : stimulus
    bus.ms_tick       = 1'b0;
    bus.current_state = 3'd0;
    #2 rst_n = 1'b0;
    #1 checkResetValues("por");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    modelReset();

    // Green ramps up and saturates; idle cycles wander the sector to prove ticks gate updates.
    for (int i = 0; i < 9; i++) begin
      applyStimulus(0, 1'b1);
      repeat ($urandom_range(0, 3)) applyStimulus($urandom_range(0, 7), 1'b0);
    end
    checkOutput("sat_green", int'(bus.green_duty), M);
    checkOutput("sat_red",   int'(bus.red_duty),   M);
    checkOutput("sat_blue",  int'(bus.blue_duty),  0);

    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1'b1);
      repeat ($urandom_range(0, 3)) applyStimulus(1, 1'b0);
    end
    checkOutput("dec3_red",   int'(bus.red_duty),   5);
    checkOutput("dec3_green", int'(bus.green_duty), M);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1'b1);
    checkOutput("dec_floor_red", int'(bus.red_duty), 0);

    // Ticks landing on the last count of a period must only show up one period later.
    for (int k = 0; k < 2; k++) begin
      while (hist_r.size() % M != 0) applyStimulus(2, 1'b0);
      applyStimulus(2, 1'b1);
      repeat (2 * M) applyStimulus(2, 1'b0);
    end
    checkOutput("aligned_blue", int'(bus.blue_duty), 2);

    applyStimulus(6, 1'b1);
    applyStimulus(7, 1'b1);
    checkOutput("invalid_hold_blue",  int'(bus.blue_duty),  2);
    checkOutput("invalid_hold_green", int'(bus.green_duty), M);
    applyStimulus(2, 1'b1);
    checkOutput("resume_blue", int'(bus.blue_duty), 3);
    repeat (M) applyStimulus(2, 1'b0);

    asyncReset("rst_a");
    for (int i = 0; i < 4; i++) applyStimulus(0, 1'b1);
    checkOutput("midramp_green", int'(bus.green_duty), 4);
    repeat (3) applyStimulus(0, 1'b0);
    asyncReset("rst_midramp");

    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(0, 7), ($urandom_range(0, 3) == 0));
    end
    repeat (3 * M) applyStimulus(5, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #3;
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
